// File: rtl/toggle_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// toggle_pulse_conditioner
//
// Turns a raw, asynchronous, bouncy push-button into a clean one-cycle strobe
// for the T input of a downstream toggle flip-flop. It also provides the
// debounced button level.
//
// Processing chain:
//   btn_in -> two-flop synchronizer -> debounce FSM -> registered one-pulse
//
// Optional feature (macro AUTO_REPEAT_EN):
//   While the button stays accepted, the block issues extra strobes. The first
//   repeat strobe comes REPEAT_DELAY cycles after the press strobe. Later
//   strobes follow every REPEAT_PERIOD cycles. When the macro is undefined the
//   block issues exactly one strobe per accepted press.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable synchronized samples needed to accept an edge (>=2)
//   CNT_W            width of the debounce and repeat counters
//   REPEAT_DELAY     HELD cycles before the first repeat strobe
//   REPEAT_PERIOD    cycles between later repeat strobes (>=2)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   btn_in     raw button, asynchronous to clk, may bounce
//   t_pulse    registered single-cycle toggle strobe
//   btn_level  registered debounced button level
//   busy       high while a press or release is being qualified
// -----------------------------------------------------------------------------
module toggle_pulse_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8,
  parameter int unsigned REPEAT_DELAY    = 8,
  parameter int unsigned REPEAT_PERIOD   = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic t_pulse,
  output logic btn_level,
  output logic busy
);

  // A debounce window of fewer than two samples cannot work, so it is clamped.
  localparam int unsigned DB_EFF = (DEBOUNCE_CYCLES < 2) ? 2 : DEBOUNCE_CYCLES;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_EFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             t_pulse_n, btn_level_n;
  logic             sync1, btn_s;

`ifdef AUTO_REPEAT_EN
  // Keep repeat strobes at least two cycles apart. This lets the downstream
  // toggle flip-flop see each strobe as a separate event.
  localparam int unsigned RPT_PERIOD_EFF = (REPEAT_PERIOD < 2) ? 2 : REPEAT_PERIOD;
  localparam logic [CNT_W-1:0] RPT_LAST   = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_RELOAD = CNT_W'(REPEAT_DELAY - RPT_PERIOD_EFF);

  logic [CNT_W-1:0] rpt, rpt_n;
`else
  logic unused_cfg;
  assign unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Two-flop synchronizer. Only btn_s reaches the FSM.
  // NOTE: sequential state uses non-blocking (<=) assignments. Each flop then
  // samples the value from before the clock edge, so sync1 -> btn_s really is
  // two stages and does not collapse into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      btn_s <= 1'b0;
    end else begin
      sync1 <= btn_in;
      btn_s <= sync1;
    end
  end

  // State and output registers. The async reset also clears a strobe that is
  // high at that moment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      t_pulse   <= 1'b0;
      btn_level <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rpt       <= '0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      t_pulse   <= t_pulse_n;
      btn_level <= btn_level_n;
`ifdef AUTO_REPEAT_EN
      rpt       <= rpt_n;
`endif
    end
  end

  // Next-state logic. The debounce counter returns to zero whenever no
  // qualification window is open. Each wait state loads it with 1 on entry, so
  // it can never pass CNT_LAST.
  // NOTE: every signal gets a default before the case statement. Any path
  // that left one unassigned would infer a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = '0;
    t_pulse_n   = 1'b0;
    btn_level_n = btn_level;
`ifdef AUTO_REPEAT_EN
    rpt_n       = rpt;
`endif
    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;               // bounce: drop back silently
        end else if (cnt == CNT_LAST) begin
          state_n     = HELD;
          t_pulse_n   = 1'b1;
          btn_level_n = 1'b1;
`ifdef AUTO_REPEAT_EN
          rpt_n       = '0;
`endif
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          // Release takes priority over a repeat strobe due in this cycle.
          // rpt keeps its value while the release is being qualified.
          state_n = RELEASE_WAIT;
          cnt_n   = CNT_W'(1);
        end else begin
`ifdef AUTO_REPEAT_EN
          if (rpt == RPT_LAST) begin
            t_pulse_n = 1'b1;
            rpt_n     = RPT_RELOAD;
          end else begin
            rpt_n = rpt + 1'b1;
          end
`endif
        end
      end
      RELEASE_WAIT: begin
        if (btn_s) begin
          state_n = HELD;               // release bounce: no strobe
`ifdef AUTO_REPEAT_EN
          rpt_n   = '0;
`endif
        end else if (cnt == CNT_LAST) begin
          state_n     = IDLE;
          btn_level_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == PRESS_WAIT) || (state == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_toggle_pulse_conditioner.sv
// -----------------------------------------------------------------------------
// tb_toggle_pulse_conditioner
//
// Directed bench for toggle_pulse_conditioner with D=4, REPEAT_DELAY=8 and
// REPEAT_PERIOD=4. Inputs change on the falling clock edge. Outputs are also
// sampled on the falling edge.
//
// "Tick i" means the i-th falling edge after btn_in was driven. At that point
// the outputs reflect the state after rising edge k+i-1, where k is the first
// rising edge that samples the new btn_in value.
// -----------------------------------------------------------------------------
module tb_toggle_pulse_conditioner;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic t_pulse, btn_level, busy;

  int checks   = 0;
  int failures = 0;

  toggle_pulse_conditioner #(
    .DEBOUNCE_CYCLES (4),
    .CNT_W           (8),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .t_pulse   (t_pulse),
    .btn_level (btn_level),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] bit_at(input int i);
    return 64'd1 << i;
  endfunction

  // Runs n ticks. Records which ticks had t_pulse high, the first tick where
  // btn_level left its starting value (0 if it never did), and how many ticks
  // had busy high.
  task automatic watch(input int n, output int pulses, output logic [63:0] mask,
                       output int lvl_tick, output int busy_cnt);
    logic start_lvl;
    start_lvl = btn_level;
    pulses    = 0;
    mask      = '0;
    lvl_tick  = 0;
    busy_cnt  = 0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (t_pulse) begin
        pulses++;
        mask[i] = 1'b1;
      end
      if (btn_level !== start_lvl && lvl_tick == 0) lvl_tick = i;
      if (busy) busy_cnt++;
    end
  endtask

  int          pulses, lvl_tick, busy_cnt;
  int          acc_pulses, acc_busy, acc_lvl;
  logic [63:0] mask, exp_hold;
  int          pat[6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    // 1: reset held with the button pressed; all outputs stay low.
    rst    = 1'b1;
    btn_in = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_t_pulse", t_pulse, 0);
      check("rst_level", btn_level, 0);
      check("rst_busy", busy, 0);
    end
    rst = 1'b0;
    watch(10, pulses, mask, lvl_tick, busy_cnt);
    check("s1_pulse_mask", mask, bit_at(6));
    check("s1_level_rise", lvl_tick, 6);
    check("s1_busy_cycles", busy_cnt, 3);

    btn_in = 1'b0;
    watch(10, pulses, mask, lvl_tick, busy_cnt);
    check("s1_release_mask", mask, 0);
    check("s1_level_fall", lvl_tick, 6);
    check("s1_release_busy", busy_cnt, 3);

    // 2: clean press held long. Without repeat, one strobe at tick 6.
    //    With repeat, further strobes 8, 12, 16, ... ticks after it.
    exp_hold = bit_at(6);
`ifdef AUTO_REPEAT_EN
    for (int t = 14; t <= 34; t += 4) exp_hold |= bit_at(t);
`endif
    btn_in = 1'b1;
    watch(35, pulses, mask, lvl_tick, busy_cnt);
    check("s2_hold_mask", mask, exp_hold);
    check("s2_level_rise", lvl_tick, 6);
    check("s2_level_held", btn_level, 1);
    btn_in = 1'b0;
    watch(10, pulses, mask, lvl_tick, busy_cnt);
    check("s2_release_mask", mask, 0);
    check("s2_level_fall", lvl_tick, 6);

    // 3: bouncy press 1,0,1,1,0,1 then stable high. The strobe comes five
    //    edges after the last rising sample.
    acc_pulses = 0;
    acc_busy   = 0;
    acc_lvl    = 0;
    for (int i = 0; i < 6; i++) begin
      btn_in = pat[i][0];
      watch(1, pulses, mask, lvl_tick, busy_cnt);
      acc_pulses += pulses;
      acc_busy   += busy_cnt;
      acc_lvl    += lvl_tick;
    end
    check("s3_bounce_pulses", acc_pulses, 0);
    check("s3_bounce_level", acc_lvl, 0);
    check("s3_bounce_busy", acc_busy, 3);
    btn_in = 1'b1;
    watch(9, pulses, mask, lvl_tick, busy_cnt);
    check("s3_pulse_mask", mask, bit_at(5));
    check("s3_level_rise", lvl_tick, 5);
    check("s3_busy_cycles", busy_cnt, 3);

    // 4: release bounce (low for two samples), then a real release.
    btn_in = 1'b0;
    watch(2, pulses, mask, lvl_tick, busy_cnt);
    acc_pulses = pulses;
    acc_busy   = busy_cnt;
    acc_lvl    = lvl_tick;
    btn_in = 1'b1;
    watch(7, pulses, mask, lvl_tick, busy_cnt);
    acc_pulses += pulses;
    acc_busy   += busy_cnt;
    acc_lvl    += lvl_tick;
    check("s4_bounce_pulses", acc_pulses, 0);
    check("s4_bounce_level", acc_lvl, 0);
    check("s4_bounce_busy", acc_busy, 2);
    check("s4_level_still_high", btn_level, 1);
    btn_in = 1'b0;
    watch(6, pulses, mask, lvl_tick, busy_cnt);
    check("s4_release_mask", mask, 0);
    check("s4_level_fall", lvl_tick, 6);
    check("s4_release_busy", busy_cnt, 3);

    // 6: reset asserted while the strobe is high clears it before the next
    //    rising edge. A press afterwards needs the full latency again.
    btn_in = 1'b1;
    watch(6, pulses, mask, lvl_tick, busy_cnt);
    check("s6_pulse_mask", mask, bit_at(6));
    check("s6_pulse_now", t_pulse, 1);
    #1 rst = 1'b1;
    #1;
    check("s6_async_t_pulse", t_pulse, 0);
    check("s6_async_level", btn_level, 0);
    check("s6_async_busy", busy, 0);
    @(negedge clk);
    check("s6_rst_t_pulse", t_pulse, 0);
    check("s6_rst_level", btn_level, 0);
    rst = 1'b0;
    watch(10, pulses, mask, lvl_tick, busy_cnt);
    check("s6_relatch_mask", mask, bit_at(6));
    check("s6_relatch_level", lvl_tick, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
